// File: rtl/rob_retire.sv
`default_nettype none
// ============================================================================
//  Module   : rob_retire
//  Purpose  : Circular reorder buffer with N_WAY in-order dispatch, CDB
//             completion marking and N_WAY in-order prefix retirement.
//  Revision : 1.0 - initial release
// ============================================================================
module rob_retire #(
    parameter  int N_WAY     = 2,
    parameter  int ROB_DEPTH = 8,
    parameter  int TAG_BITS  = 6,
    localparam int IDX_BITS  = $clog2(ROB_DEPTH),
    localparam int CNT_BITS  = IDX_BITS + 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_WAY-1:0]             disp_valid,
    input  logic [N_WAY*TAG_BITS-1:0]    disp_tag,
    input  logic [N_WAY*TAG_BITS-1:0]    disp_tag_old,
    output logic                         disp_stall,
    output logic [N_WAY*IDX_BITS-1:0]    disp_rob_idx,
    input  logic [N_WAY-1:0]             cdb_valid,
    input  logic [N_WAY*IDX_BITS-1:0]    cdb_rob_idx,
    input  logic                         flush,
    output logic [N_WAY-1:0]             ret_valid,
    output logic [N_WAY*TAG_BITS-1:0]    ret_tag,
    output logic [N_WAY*TAG_BITS-1:0]    ret_tag_old,
    output logic [CNT_BITS-1:0]          rob_count,
    output logic                         empty,
    output logic                         full
);

    localparam logic [CNT_BITS-1:0] c_DEPTH = CNT_BITS'(ROB_DEPTH);
    localparam logic [CNT_BITS-1:0] c_NWAY  = CNT_BITS'(N_WAY);

    logic                r_valid    [ROB_DEPTH];
    logic                r_complete [ROB_DEPTH];
    logic [TAG_BITS-1:0] r_tag      [ROB_DEPTH];
    logic [TAG_BITS-1:0] r_tag_old  [ROB_DEPTH];
    logic [IDX_BITS-1:0] r_head;
    logic [IDX_BITS-1:0] r_tail;
    logic [CNT_BITS-1:0] r_count;

    logic [IDX_BITS-1:0] w_ret_idx  [N_WAY];
    logic [IDX_BITS-1:0] w_disp_idx [N_WAY];
    logic [N_WAY-1:0]    w_ret_valid;
    logic                w_prefix;
    logic [CNT_BITS-1:0] w_n_ret;
    logic [CNT_BITS-1:0] w_n_disp;
    logic                w_stall;

    generate
        for (genvar g = 0; g < N_WAY; g++) begin : g_lane
            assign w_ret_idx[g]  = r_head + IDX_BITS'(g);
            assign w_disp_idx[g] = r_tail + IDX_BITS'(g);
            assign disp_rob_idx[g*IDX_BITS +: IDX_BITS] =
                reset ? w_disp_idx[g] : IDX_BITS'(g);
        end
    endgenerate

    // Stall looks only at the registered occupancy, never at this cycle's retirements.
    assign w_stall = (c_DEPTH - r_count) < c_NWAY;

    always_comb begin
        w_ret_valid = '0;
        w_n_ret     = '0;
        w_prefix    = reset & ~flush;
        for (int i = 0; i < N_WAY; i++) begin
            w_prefix       = w_prefix & r_valid[w_ret_idx[i]] & r_complete[w_ret_idx[i]];
            w_ret_valid[i] = w_prefix;
            if (w_prefix) begin
                w_n_ret = w_n_ret + CNT_BITS'(1);
            end
        end
    end

    always_comb begin
        w_n_disp = '0;
        if (!w_stall) begin
            for (int i = 0; i < N_WAY; i++) begin
                if (disp_valid[i]) begin
                    w_n_disp = w_n_disp + CNT_BITS'(1);
                end
            end
        end
    end

    always_comb begin
        ret_tag     = '0;
        ret_tag_old = '0;
        for (int i = 0; i < N_WAY; i++) begin
            if (w_ret_valid[i]) begin
                ret_tag[i*TAG_BITS +: TAG_BITS]     = r_tag[w_ret_idx[i]];
                ret_tag_old[i*TAG_BITS +: TAG_BITS] = r_tag_old[w_ret_idx[i]];
            end
        end
    end

    assign ret_valid  = w_ret_valid;
    assign rob_count  = reset ? r_count : '0;
    assign empty      = (rob_count == '0);
    assign full       = (rob_count == c_DEPTH);
    assign disp_stall = reset & w_stall;

    // Later non-blocking writes win: CDB, then retire clear, then dispatch.
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            for (int e = 0; e < ROB_DEPTH; e++) begin
                r_valid[e]    <= 1'b0;
                r_complete[e] <= 1'b0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < N_WAY; i++) begin
                if (cdb_valid[i] && r_valid[cdb_rob_idx[i*IDX_BITS +: IDX_BITS]]) begin
                    r_complete[cdb_rob_idx[i*IDX_BITS +: IDX_BITS]] <= 1'b1;
                end
            end
            for (int i = 0; i < N_WAY; i++) begin
                if (w_ret_valid[i]) begin
                    r_valid[w_ret_idx[i]]    <= 1'b0;
                    r_complete[w_ret_idx[i]] <= 1'b0;
                end
            end
            if (!w_stall) begin
                for (int i = 0; i < N_WAY; i++) begin
                    if (disp_valid[i]) begin
                        r_valid[w_disp_idx[i]]    <= 1'b1;
                        r_complete[w_disp_idx[i]] <= 1'b0;
                        r_tag[w_disp_idx[i]]      <= disp_tag[i*TAG_BITS +: TAG_BITS];
                        r_tag_old[w_disp_idx[i]]  <= disp_tag_old[i*TAG_BITS +: TAG_BITS];
                    end
                end
            end
            r_head  <= r_head + w_n_ret[IDX_BITS-1:0];
            r_tail  <= r_tail + w_n_disp[IDX_BITS-1:0];
            r_count <= r_count + w_n_disp - w_n_ret;
        end
    end

endmodule
`default_nettype wire

// File: doc/rob_retire.md
ROB_RETIRE -- requirements
Module: rob_retire

Interface
REQ-001 Parameter: N_WAY, 2, dispatch/complete/retire lanes per cycle; lane 0 is oldest.
REQ-002 Parameter: ROB_DEPTH, 8, entries; power of 2, >= 2*N_WAY.
REQ-003 Parameter: TAG_BITS, 6, physical tag width (matches CDB tag width).
REQ-004 Derived: IDX_BITS = log2(ROB_DEPTH); CNT_BITS = IDX_BITS+1.
REQ-005 clock  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-low (0 = reset).
REQ-007 disp_valid  in  N_WAY  dispatch request per lane; contiguous from lane 0.
REQ-008 disp_tag  in  N_WAY*TAG_BITS  new physical tag per lane.
REQ-009 disp_tag_old  in  N_WAY*TAG_BITS  previously mapped physical tag per lane.
REQ-010 disp_stall  out  1  high when free entries < N_WAY.
REQ-011 disp_rob_idx  out  N_WAY*IDX_BITS  entry index for lane i: (tail+i) mod ROB_DEPTH.
REQ-012 cdb_valid  in  N_WAY  completion broadcast per lane.
REQ-013 cdb_rob_idx  in  N_WAY*IDX_BITS  entry index being completed.
REQ-014 flush  in  1  discard all entries.
REQ-015 ret_valid  out  N_WAY  retire lane valid; drives ret_valid field of retire packet.
REQ-016 ret_tag  out  N_WAY*TAG_BITS  retiring tag; drives tag field.
REQ-017 ret_tag_old  out  N_WAY*TAG_BITS  retiring old tag; drives tag_old field.
REQ-018 rob_count  out  CNT_BITS  occupied entries.
REQ-019 empty / full  out  1 each  rob_count==0 / rob_count==ROB_DEPTH.

Function
REQ-020 Storage: circular buffer; per entry valid, complete, tag, tag_old; head, tail pointers IDX_BITS wide, wrap mod ROB_DEPTH.
REQ-021 Dispatch all-or-nothing: when disp_stall=0, each disp_valid[i] lane writes entry tail+i (valid=1, complete=0); tail += popcount(disp_valid).
REQ-022 disp_valid while disp_stall=1: ignored entirely, no state change.
REQ-023 disp_stall derived from current registered count only; same-cycle retirements do not relieve it.
REQ-024 Non-contiguous disp_valid is illegal; behaviour undefined, not driven by bench.
REQ-025 Completion: cdb_valid[i] sets complete on entry cdb_rob_idx[i] at next edge if entry valid; ignored if entry invalid.
REQ-026 Retire combinational from registered state: ret_valid[i]=1 iff entries head..head+i all valid and complete (prefix rule, in order).
REQ-027 ret_tag/ret_tag_old[i] = entry head+i fields; 0 when ret_valid[i]=0.
REQ-028 At edge: retired entries cleared (valid=0, complete=0); head += popcount(ret_valid).
REQ-029 Completion latency: CDB in cycle N -> earliest ret_valid in cycle N+1; same-cycle CDB does not retire.
REQ-030 Count: count_next = count + n_disp - n_ret; dispatch and retire in same cycle both take effect.
REQ-031 Wrap: retire/dispatch groups may span index ROB_DEPTH-1 -> 0 in one cycle.
REQ-032 Retire at most N_WAY per cycle even if more are complete.
REQ-033 flush=1: ret_valid forced 0 that cycle; next edge head=tail=0, count=0, all entries cleared; dispatch and CDB that cycle ignored.

Reset
REQ-034 reset=0 at edge: head=0, tail=0, count=0, all valid/complete=0.
REQ-035 Outputs during/after reset: ret_valid=0, ret_tag=0, ret_tag_old=0, rob_count=0, empty=1, full=0, disp_stall=0, disp_rob_idx lane i = i.
REQ-036 Reset overrides flush, dispatch, CDB in the same cycle; mid-operation reset discards all entries with no retirement.

Verification
REQ-037 Reset then dispatch 2 lanes tag={7,8}, old={1,2} -> disp_rob_idx={0,1}, rob_count=2, no retire.
REQ-038 CDB idx 1 then idx 0 one cycle later -> no retire until cycle after idx 0 completes, then ret_valid=2'b11, ret_tag={7,8}, ret_tag_old={1,2}.
REQ-039 Fill 8 entries (4 dispatch cycles) -> full=1, disp_stall=1; further dispatch ignored, count stays 8.
REQ-040 Head at 7, entries 7 and 0 complete -> both retire in one cycle, head wraps to 1.
REQ-041 Complete only idx 1 of {0,1} -> ret_valid=0; with count=6, dispatch 2 plus retire 2 same cycle -> count=6.
REQ-042 Flush with 5 entries, or reset=0 mid-stream -> ret_valid=0 that cycle, next cycle count=0, empty=1, disp_rob_idx={0,1}.
